hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Hazard and stall controller for the five-stage MIPS pipeline.
- Detects load-use, branch-compare and HI/LO (multiply/divide) hazards.
- Drives StallF, StallD, FlushD and FlushE into the IF/ID and ID/EX pipeline registers, and the forwarding muxes in D and E.
- Sequences the multi-cycle multiply/divide unit with an internal busy FSM and down-counter.

## Interface
Parameters:
- MULT_CYCLES, 5, multiply latency in cycles (1..255)
- DIV_CYCLES, 10, divide latency in cycles (1..255)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- RsD, RtD  in  5  source registers of instruction in D
- RsE, RtE  in  5  source registers of instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enable per stage
- MemtoRegE, MemtoRegM  in  1  load instruction in E / M
- BranchD  in  1  instruction in D compares registers (beq/bne/jr)
- PCSrcD  in  1  control transfer taken, resolved in D
- MDStartE  in  1  mult/div in E this cycle, unstalled
- MDDivE  in  1  1 = div, 0 = mult (valid with MDStartE)
- MDUseD  in  1  instruction in D uses HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- StallF, StallD  out  1  hold PC / IF-ID register
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register
- ForwardAD, ForwardBD  out  1  forward ALUOutM to D comparator operand A/B
- ForwardAE, ForwardBE  out  2  E operand select: 00 register file, 10 from M, 01 from W
- MDBusy  out  1  multiply/divide in progress

## Operation
**Forwarding** (register 0 never matches):
- ForwardAE = 10 if RegWriteM and RsE == WriteRegM.
- Otherwise ForwardAE = 01 if RegWriteW and RsE == WriteRegW.
- Otherwise ForwardAE = 00.
- ForwardBE is the same using RtE.
- ForwardAD = RegWriteM and RsD == WriteRegM. ForwardBD is the same using RtD.

**Stall terms** ("matches D" means (RsD or RtD) equals the register, register nonzero):
- lwstall = MemtoRegE and WriteRegE matches D.
- branchstall = BranchD and (RegWriteE and WriteRegE matches D, or MemtoRegM and WriteRegM matches D).
- mdstall = MDUseD and (MDBusy or MDStartE).
- stall = lwstall | branchstall | mdstall.

**Stall and flush outputs:**
- StallF = StallD = FlushE = stall.
- FlushD = PCSrcD & ~stall. Stall wins over flush.

**MDU FSM**, states IDLE and BUSY, 8-bit down-counter cnt:
- IDLE, MDStartE = 1: go to BUSY, cnt <= (MDDivE ? DIV_CYCLES : MULT_CYCLES) - 1.
- BUSY, cnt != 0: cnt <= cnt - 1.
- BUSY, cnt == 0: go to IDLE.
- MDStartE while BUSY is ignored: no reload, no state change. This cannot occur in a legal pipeline, because a mult/div in D stalls.
- MDBusy = (state == BUSY).

**Reset:**
- RST = 1 at a clock edge sets state IDLE and cnt 0, including mid-operation.
- While RST = 1, outputs are forced combinationally: StallF = StallD = 0, FlushD = FlushE = 1, all Forward* = 0, MDBusy = 0.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and registered state, all in the same cycle.
- The only registers are the FSM state and cnt.
- Mult/div latency, with MDStartE in cycle t and N the selected latency:
  - MDBusy is high in cycles t+1 .. t+N.
  - A HI/LO user in D is stalled in cycles t .. t+N.
  - It advances at the end of cycle t+N+1.
- N = 1: BUSY for exactly one cycle.
- Back-to-back: a new MDStartE in the cycle after BUSY → IDLE is accepted normally.
- lwstall: exactly one stall cycle per load-use pair. branchstall: one cycle for an ALU producer in E, one further cycle for a load in M.

## Configuration
- Macro: HAZARD_MDU_EN.
- Defined: the MDU FSM, counter and mdstall are present as specified.
- Undefined: no FSM or counter is instantiated, MDBusy is tied 0, mdstall is 0, and MDStartE, MDDivE and MDUseD are unused. Parameters remain declared.

## Test plan
- Forwarding priority: RsE = 5, WriteRegM = 5, WriteRegW = 5, both RegWrite = 1 → ForwardAE = 10. With RsE = 0 instead → ForwardAE = 00.
- Load-use: MemtoRegE = 1, WriteRegE = 8, RtD = 8 → StallF = StallD = FlushE = 1 for one cycle. With RtD = 9 → all 0.
- Branch vs stall: BranchD = 1, RsD = 3, RegWriteE = 1, WriteRegE = 3, PCSrcD = 1 → StallD = 1, FlushD = 0. After the producer moves to M → StallD = 0, ForwardAD = 1, FlushD = 1.
- Divide: MDStartE = 1, MDDivE = 1 at t, MDUseD held 1 → MDBusy high for exactly 10 cycles (t+1..t+10), StallD high for t..t+10, low at t+11. Mult gives 5 cycles.
- Reset mid-divide: RST = 1 at t+4 → MDBusy = 0 and FlushD = FlushE = 1 during reset. After release with MDUseD = 1, no stall.
- HAZARD_MDU_EN undefined: the divide scenario yields MDBusy = 0 and StallD = 0 throughout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and stall controller for the five-stage MIPS pipeline.
//
// Detects load-use, branch-compare and HI/LO (multiply/divide) hazards, drives
// the IF/ID and ID/EX stall/flush controls and the D/E forwarding selects, and
// sequences the multi-cycle multiply/divide unit.
//
// Configuration macro: HAZARD_MDU_EN
//   defined   : MDU busy FSM, 8-bit down-counter and mdstall are built.
//   undefined : no FSM/counter, MDBusy = 0, mdstall = 0; MDStartE, MDDivE and
//               MDUseD are ignored.
//
// Ports:
//   CLK, RST                       clock (rising edge), synchronous active-high reset
//   RsD, RtD / RsE, RtE            source registers of the instructions in D / E
//   WriteRegE/M/W, RegWriteE/M/W   destination register and write enable per stage
//   MemtoRegE, MemtoRegM           load instruction in E / M
//   BranchD, PCSrcD                register-compare in D, taken transfer in D
//   MDStartE, MDDivE, MDUseD       mult/div issue in E, div select, HI/LO user in D
//   StallF, StallD, FlushD, FlushE pipeline register controls
//   ForwardAD, ForwardBD           forward ALUOutM to the D comparator operands
//   ForwardAE, ForwardBE           E operand select: 00 regfile, 10 M, 01 W
//   MDBusy                         multiply/divide in progress
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MDStartE,
    input  logic       MDDivE,
    input  logic       MDUseD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MDBusy
);

    // Counter load values: the counter runs N-1 .. 0, giving N busy cycles.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic matches_d(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] r);
        return (r != 5'd0) && ((rs == r) || (rt == r));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWriteM && (src != 5'd0) && (src == WriteRegM))
            return 2'b10;
        else if (RegWriteW && (src != 5'd0) && (src == WriteRegW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    logic [1:0] fwd_ae;
    logic [1:0] fwd_be;
    logic       fwd_ad;
    logic       fwd_bd;
    logic       lw_stall;
    logic       branch_stall;
    logic       md_stall;
    logic       md_busy;
    logic       stall;

    always_comb begin
        fwd_ae = fwd_sel(RsE);
        fwd_be = fwd_sel(RtE);
        fwd_ad = RegWriteM && (RsD != 5'd0) && (RsD == WriteRegM);
        fwd_bd = RegWriteM && (RtD != 5'd0) && (RtD == WriteRegM);

        lw_stall     = MemtoRegE && matches_d(RsD, RtD, WriteRegE);
        branch_stall = BranchD &&
                       ((RegWriteE && matches_d(RsD, RtD, WriteRegE)) ||
                        (MemtoRegM && matches_d(RsD, RtD, WriteRegM)));
    end

`ifdef HAZARD_MDU_EN
    // MDU busy FSM
    //   state | meaning
    //   IDLE  | no mult/div outstanding; accepts MDStartE
    //   BUSY  | mult/div in progress; cnt counts remaining cycles down to 0
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    md_state_t  state;
    md_state_t  state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A start while BUSY is deliberately dropped: the D-stage stall keeps a
    // legal pipeline from ever issuing one.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (MDStartE) begin
                    state_next = BUSY;
                    cnt_next   = MDDivE ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != 8'd0)
                    cnt_next = cnt - 8'd1;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        md_busy  = (state == BUSY);
        md_stall = MDUseD && (md_busy || MDStartE);
    end
`else
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
    wire   md_unused = &{1'b0, MDStartE, MDDivE, MDUseD, MULT_LOAD, DIV_LOAD};
`endif

    assign stall = lw_stall | branch_stall | md_stall;

    // Reset overrides everything so the pipeline registers are cleared while
    // held, regardless of what the datapath presents.
    always_comb begin
        if (RST) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            ForwardAD = 1'b0;
            ForwardBD = 1'b0;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
            MDBusy    = 1'b0;
        end else begin
            StallF    = stall;
            StallD    = stall;
            FlushE    = stall;
            FlushD    = PCSrcD && !stall;
            ForwardAD = fwd_ad;
            ForwardBD = fwd_bd;
            ForwardAE = fwd_ae;
            ForwardBE = fwd_be;
            MDBusy    = md_busy;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven combinational vectors plus
// hand-written multi-cycle sequences for the MDU and reset.
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, MDStartE, MDDivE, MDUseD;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MDBusy;
    logic [1:0] ForwardAE, ForwardBE;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .CLK(CLK), .RST(RST),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD),
        .MDStartE(MDStartE), .MDDivE(MDDivE), .MDUseD(MDUseD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MDBusy(MDBusy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, mem_e, mem_m, branch, pcsrc;
        logic       x_stall, x_flushd, x_fad, x_fbd;
        logic [1:0] x_fae, x_fbe;
    } vec_t;

    vec_t tbl[$];

    // Packed view of all outputs: {StallF,StallD,FlushE,FlushD,FAD,FBD,FAE,FBE,MDBusy}
    function automatic logic [10:0] outs();
        return {StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD,
                ForwardAE, ForwardBE, MDBusy};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PCSrcD = 0;
        MDStartE = 0; MDDivE = 0; MDUseD = 0;
    endtask

    task automatic apply(input vec_t v);
        RsD = v.rs_d; RtD = v.rt_d; RsE = v.rs_e; RtE = v.rt_e;
        WriteRegE = v.wr_e; WriteRegM = v.wr_m; WriteRegW = v.wr_w;
        RegWriteE = v.rw_e; RegWriteM = v.rw_m; RegWriteW = v.rw_w;
        MemtoRegE = v.mem_e; MemtoRegM = v.mem_m;
        BranchD = v.branch; PCSrcD = v.pcsrc;
    endtask

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    // Drive just after the rising edge, sample on the falling edge.
    task automatic step_drive();
        @(posedge CLK);
        #1;
    endtask

    task automatic step_sample();
        @(negedge CLK);
    endtask

    // One mult/div issue at k=0 with a HI/LO user held in D; checks MDBusy
    // and StallD for cycles 0..n. poke >= 0 re-asserts MDStartE while busy.
    task automatic md_run(input string tag, input logic div, input int n, input int poke);
        for (int k = 0; k <= n; k++) begin
            step_drive();
            MDUseD   = 1'b1;
            MDStartE = (k == 0) || (k == poke);
            MDDivE   = (k == poke) ? ~div : div;
            step_sample();
`ifdef HAZARD_MDU_EN
            check($sformatf("%s busy k=%0d", tag, k), 16'(MDBusy), 16'((k >= 1) && (k <= n)));
            check($sformatf("%s stalld k=%0d", tag, k), 16'(StallD), 16'(1));
`else
            check($sformatf("%s busy k=%0d", tag, k), 16'(MDBusy), 16'(0));
            check($sformatf("%s stalld k=%0d", tag, k), 16'(StallD), 16'(0));
`endif
        end
    endtask

    task automatic md_idle_check(input string tag);
        step_drive();
        MDStartE = 1'b0;
        MDUseD   = 1'b1;
        step_sample();
        check({tag, " busy"}, 16'(MDBusy), 16'(0));
        check({tag, " stalld"}, 16'(StallD), 16'(0));
    endtask

    initial begin
        vec_t v;

        v = '{default: '0, name: "fwd_prio_M"};
        v.rs_e = 5; v.wr_m = 5; v.wr_w = 5; v.rw_m = 1; v.rw_w = 1; v.x_fae = 2'b10; add(v);
        v = '{default: '0, name: "fwd_r0"};
        v.rw_m = 1; v.rw_w = 1; add(v);
        v = '{default: '0, name: "fwd_W_only"};
        v.rt_e = 7; v.wr_m = 7; v.wr_w = 7; v.rw_w = 1; v.x_fbe = 2'b01; add(v);
        v = '{default: '0, name: "fwd_both_M"};
        v.rs_e = 6; v.rt_e = 6; v.wr_m = 6; v.rw_m = 1; v.x_fae = 2'b10; v.x_fbe = 2'b10; add(v);
        v = '{default: '0, name: "fwd_D"};
        v.rs_d = 4; v.rt_d = 4; v.wr_m = 4; v.rw_m = 1; v.x_fad = 1; v.x_fbd = 1; add(v);
        v = '{default: '0, name: "lw_use"};
        v.mem_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 8; v.x_stall = 1; add(v);
        v = '{default: '0, name: "lw_after"};
        v.mem_m = 1; v.rw_m = 1; v.wr_m = 8; v.rt_d = 8; v.x_fbd = 1; add(v);
        v = '{default: '0, name: "lw_nomatch"};
        v.mem_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 9; add(v);
        v = '{default: '0, name: "lw_r0"};
        v.mem_e = 1; v.rw_e = 1; add(v);
        v = '{default: '0, name: "br_aluE"};
        v.branch = 1; v.rs_d = 3; v.rw_e = 1; v.wr_e = 3; v.pcsrc = 1; v.x_stall = 1; add(v);
        v = '{default: '0, name: "br_moved"};
        v.branch = 1; v.rs_d = 3; v.rw_m = 1; v.wr_m = 3; v.pcsrc = 1;
        v.x_fad = 1; v.x_flushd = 1; add(v);
        v = '{default: '0, name: "br_loadM"};
        v.branch = 1; v.rt_d = 10; v.mem_m = 1; v.rw_m = 1; v.wr_m = 10;
        v.x_stall = 1; v.x_fbd = 1; add(v);
        v = '{default: '0, name: "nobr_aluE"};
        v.rs_d = 3; v.rw_e = 1; v.wr_e = 3; v.pcsrc = 1; v.x_flushd = 1; add(v);
        v = '{default: '0, name: "br_noRW"};
        v.branch = 1; v.rs_d = 3; v.wr_e = 3; add(v);

        // Reset with hazard-producing inputs: outputs must be forced.
        clear_inputs();
        RST = 1'b1;
        apply(tbl[0]);
        BranchD = 1; RsD = 5; RegWriteE = 1; WriteRegE = 5; MemtoRegE = 1;
        step_sample();
        check("reset_outs", 16'(outs()), 16'(11'b000_1_00_00_00_0 | 11'b001_1_00_00_00_0));
        step_drive();
        step_sample();
        check("reset_outs2", 16'(outs()), 16'(11'b001_1_00_00_00_0));
        step_drive();
        RST = 1'b0;
        clear_inputs();

        foreach (tbl[i]) begin
            apply(tbl[i]);
            step_sample();
            check(tbl[i].name, 16'(outs()),
                  16'({tbl[i].x_stall, tbl[i].x_stall, tbl[i].x_stall, tbl[i].x_flushd,
                       tbl[i].x_fad, tbl[i].x_fbd, tbl[i].x_fae, tbl[i].x_fbe, 1'b0}));
            step_drive();
        end
        clear_inputs();

        md_run("div", 1'b1, 10, -1);
        md_idle_check("div_end");
        md_run("mult", 1'b0, 5, -1);
        md_run("mult_b2b", 1'b0, 5, -1);
        md_idle_check("b2b_end");
        md_run("div_poke", 1'b1, 10, 3);
        md_idle_check("poke_end");

        // Reset in the middle of a divide.
        md_run("div_rst", 1'b1, 3, -1);
        step_drive();
        MDStartE = 1'b0;
        RST      = 1'b1;
        step_sample();
        check("rst_mid busy", 16'(MDBusy), 16'(0));
        check("rst_mid flush", 16'({FlushD, FlushE, StallD}), 16'(3'b110));
        step_drive();
        RST = 1'b0;
        step_sample();
        check("rst_rel busy", 16'(MDBusy), 16'(0));
        check("rst_rel stalld", 16'(StallD), 16'(0));
        md_idle_check("rst_rel2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
